dac_spi_scheduler: RTL and testbench

DAC_SPI_SCHEDULER -- requirements
Module: dac_spi_scheduler

---
 rtl/dac_spi_scheduler.sv | 145 ++++++++++++++
 tb/tb_dac_spi_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_scheduler.sv
// rtl/dac_spi_scheduler.sv - two-chip DAC8734 SPI frame scheduler with shared sclk
// Define DAC_SCHED_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority to chip 0.
module dac_spi_scheduler #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic [23:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [23:0] req1_data,
    output logic        req1_ready,
    output logic        done0,
    output logic        done1,
    output logic        busy,
    output logic        sclk,
    output logic        csb0,
    output logic        csb1,
    output logic        sdio0,
    output logic        sdio1
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);
    localparam logic [4:0] BIT_LAST = 5'd23;

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic [7:0]  cnt_limit;
    logic        cnt_end;
    logic        phase;
    logic [4:0]  bit_cnt;
    logic [23:0] shreg;
    logic        sel;
    logic        grant_sel;
    logic        accept;
    logic        frame_active;

`ifdef DAC_SCHED_ROUND_ROBIN_EN
    logic last_sel;

    // last_sel resets to 1 so that chip 0 wins the first simultaneous request.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            last_sel <= 1'b1;
        end else if (accept) begin
            last_sel <= grant_sel;
        end
    end

    always_comb begin
        grant_sel = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_sel = ~last_sel;
        end else begin
            grant_sel = ~req0_valid;
        end
    end
`else
    always_comb begin
        grant_sel = ~req0_valid;
    end
`endif

    assign accept    = (state == IDLE) && (req0_valid || req1_valid) && !reset;
    assign cnt_limit = (state == GAP) ? GAP_LAST : DIV_LAST;
    assign cnt_end   = (cnt == cnt_limit);

    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = SETUP;
            SETUP: if (cnt_end) state_next = SHIFT;
            SHIFT: if (cnt_end && phase && (bit_cnt == BIT_LAST)) state_next = HOLD;
            HOLD:  if (cnt_end) state_next = GAP;
            GAP:   if (cnt_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // phase 0 is the sclk-low half of a period; data advances as sclk rises.
    always_ff @(posedge CLK100MHZ) begin
        if (reset) begin
            cnt     <= 8'd0;
            phase   <= 1'b0;
            bit_cnt <= 5'd0;
            shreg   <= 24'd0;
            sel     <= 1'b0;
        end else begin
            if (state == IDLE || cnt_end) begin
                cnt <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end

            if (state == SHIFT && cnt_end) begin
                phase <= ~phase;
            end else if (state != SHIFT) begin
                phase <= 1'b0;
            end

            if (state == SHIFT && cnt_end && phase) begin
                bit_cnt <= (bit_cnt == BIT_LAST) ? 5'd0 : bit_cnt + 5'd1;
            end else if (state != SHIFT) begin
                bit_cnt <= 5'd0;
            end

            if (accept) begin
                shreg <= grant_sel ? req1_data : req0_data;
                sel   <= grant_sel;
            end else if (state == SHIFT && cnt_end && !phase) begin
                shreg <= {shreg[22:0], 1'b0};
            end
        end
    end

    assign frame_active = !reset && (state == SETUP || state == SHIFT || state == HOLD);

    always_comb begin
        req0_ready = accept && !grant_sel;
        req1_ready = accept && grant_sel;
        done0      = !reset && (state == GAP) && cnt_end && !sel;
        done1      = !reset && (state == GAP) && cnt_end && sel;
        busy       = !reset && (state != IDLE);
        sclk       = !(!reset && state == SHIFT && !phase);
        csb0       = !(frame_active && !sel);
        csb1       = !(frame_active && sel);
        sdio0      = frame_active && !sel && shreg[23];
        sdio1      = frame_active && sel && shreg[23];
    end

endmodule

// File: tb/tb_dac_spi_scheduler.sv
// tb/tb_dac_spi_scheduler.sv - scoreboard bench for dac_spi_scheduler
module tb_dac_spi_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req0_valid, req1_valid;
    logic [23:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, done0, done1, busy, sclk, csb0, csb1, sdio0, sdio1;

    logic        f_reset, f_req0_valid, f_req1_valid;
    logic [23:0] f_req0_data, f_req1_data;
    logic        f_req0_ready, f_req1_ready, f_done0, f_done1, f_busy, f_sclk;
    logic        f_csb0, f_csb1, f_sdio0, f_sdio1;

    dac_spi_scheduler u_dut (
        .CLK100MHZ(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .done0(done0), .done1(done1), .busy(busy), .sclk(sclk),
        .csb0(csb0), .csb1(csb1), .sdio0(sdio0), .sdio1(sdio1)
    );

    dac_spi_scheduler #(.CLK_DIV(2), .GAP_CYCLES(1)) u_fast (
        .CLK100MHZ(clk), .reset(f_reset),
        .req0_valid(f_req0_valid), .req0_data(f_req0_data), .req0_ready(f_req0_ready),
        .req1_valid(f_req1_valid), .req1_data(f_req1_data), .req1_ready(f_req1_ready),
        .done0(f_done0), .done1(f_done1), .busy(f_busy), .sclk(f_sclk),
        .csb0(f_csb0), .csb1(f_csb1), .sdio0(f_sdio0), .sdio1(f_sdio1)
    );

    typedef struct {
        logic        chip;
        logic [23:0] data;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    int          t_acc = 0;
    bit          in_frame = 0;
    int          f_start = 0;
    int          f_end = 0;
    logic [23:0] cap = 0;
    int          nbits = 0;
    logic        fchip = 0;
    bit          other_bad = 0;
    logic        prev_sclk = 1'b1;

    // Frame capture on the default instance; each done pops one expected frame.
    always @(negedge clk) begin
        if (req0_ready || req1_ready) t_acc = cyc;
        if (!csb0 || !csb1) begin
            if (!in_frame) begin
                in_frame = 1; f_start = cyc; nbits = 0; cap = 0; fchip = csb0; other_bad = 0;
            end
            if (fchip ? (!csb0 || sdio0) : (!csb1 || sdio1)) other_bad = 1;
            if (prev_sclk && !sclk) begin
                cap = {cap[22:0], fchip ? sdio1 : sdio0};
                nbits++;
            end
            f_end = cyc;
        end else begin
            in_frame = 0;
        end
        prev_sclk = sclk;
        if (done0 || done1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done at cycle %0d done0=%b done1=%b", cyc, done0, done1);
            end else begin
                e = exp_q.pop_front();
                checks++;
                if (done1 !== e.chip) begin
                    errors++; $display("FAIL done_chip got done1=%b want %b", done1, e.chip);
                end
                checks++;
                if (cap !== e.data) begin
                    errors++; $display("FAIL frame_data got %h want %h", cap, e.data);
                end
                checks++;
                if (nbits != 24) begin
                    errors++; $display("FAIL frame_bits got %0d want 24", nbits);
                end
                checks++;
                if (f_start != t_acc + 1 || f_end != t_acc + 200) begin
                    errors++;
                    $display("FAIL csb_window got %0d..%0d want %0d..%0d", f_start, f_end, t_acc + 1, t_acc + 200);
                end
                checks++;
                if (cyc != t_acc + 208) begin
                    errors++; $display("FAIL done_cycle got %0d want %0d", cyc, t_acc + 208);
                end
                checks++;
                if (other_bad) begin
                    errors++; $display("FAIL idle_chip_quiet got disturbed want quiet");
                end
            end
        end
    end

    task automatic send(input logic chip, input logic [23:0] d, input bit push, output int t);
        if (push) exp_q.push_back('{chip, d});
        @(posedge clk); #2;
        if (chip) begin req1_data = d; req1_valid = 1'b1; end
        else begin req0_data = d; req0_valid = 1'b1; end
        t = -1;
        for (int i = 0; i < 400 && t < 0; i++) begin
            @(negedge clk);
            if (chip ? req1_ready : req0_ready) t = cyc;
        end
        checks++;
        if (t < 0) begin errors++; $display("FAIL send_ready got none want pulse"); end
        @(posedge clk); #2;
        if (chip) req1_valid = 1'b0; else req0_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL wait_done got %0d pending want 0", exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; f_reset = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b0; req0_data = 24'h123456; req1_data = 24'h0;
        f_req0_valid = 1'b0; f_req1_valid = 1'b0; f_req0_data = 24'h0; f_req1_data = 24'h0;
        repeat (3) @(negedge clk);
        checks++;
        if ({sclk, csb0, csb1, sdio0, sdio1, busy, req0_ready, req1_ready, done0, done1} !== 10'b1110000000) begin
            errors++;
            $display("FAIL reset_outputs got %b want 1110000000",
                     {sclk, csb0, csb1, sdio0, sdio1, busy, req0_ready, req1_ready, done0, done1});
        end
        req0_valid = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0; f_reset = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || req0_ready !== 1'b0) begin
            errors++; $display("FAIL post_reset_idle got busy=%b ready=%b want 0 0", busy, req0_ready);
        end
    endtask

    task automatic test_frame0();
        int t;
        send(1'b0, 24'hA5F00F, 1'b1, t);
        wait_idle();
    endtask

    task automatic test_frame1();
        int t;
        send(1'b1, 24'h000001, 1'b1, t);
        wait_idle();
    endtask

    task automatic test_abort();
        int t;
        int nd = 0;
        send(1'b0, 24'hC3C3C3, 1'b0, t);
        while (cyc < t + 99) @(negedge clk);
        checks++;
        if (csb0 !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_pre got csb0=%b busy=%b want 0 1", csb0, busy);
        end
        @(posedge clk); #2; reset = 1'b1;
        @(posedge clk); #2; reset = 1'b0;
        @(negedge clk);
        checks++;
        if (csb0 !== 1'b1 || sclk !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL abort_post got csb0=%b sclk=%b busy=%b want 1 1 0", csb0, sclk, busy);
        end
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (done0 || done1) nd++;
        end
        checks++;
        if (nd != 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", nd); end
    endtask

    task automatic test_arbitration();
        logic exp_chip;
        logic got;
        bit   seen;
        for (int r = 0; r < 3; r++) begin
`ifdef DAC_SCHED_ROUND_ROBIN_EN
            exp_chip = r[0];
`else
            exp_chip = 1'b0;
`endif
            exp_q.push_back('{exp_chip, exp_chip ? 24'h200000 + 24'(r) : 24'h100000 + 24'(r)});
            @(posedge clk); #2;
            req0_data = 24'h100000 + 24'(r); req1_data = 24'h200000 + 24'(r);
            req0_valid = 1'b1; req1_valid = 1'b1;
            seen = 0; got = 1'b0;
            for (int i = 0; i < 400 && !seen; i++) begin
                @(negedge clk);
                if (req0_ready || req1_ready) begin
                    seen = 1; got = req1_ready;
                    checks++;
                    if (req0_ready === req1_ready) begin
                        errors++; $display("FAIL arb_single got both ready want one");
                    end
                end
            end
            checks++;
            if (!seen || got !== exp_chip) begin
                errors++; $display("FAIL arb_grant round %0d got %b want %b", r, got, exp_chip);
            end
            @(posedge clk); #2;
            req0_valid = 1'b0; req1_valid = 1'b0;
            wait_idle();
        end
    endtask

    task automatic test_done_handoff();
        int t;
        send(1'b0, 24'h3C3C3C, 1'b1, t);
        exp_q.push_back('{1'b1, 24'h0F0F0F});
        while (cyc < t + 207) @(negedge clk);
        @(posedge clk); #2;
        req1_data = 24'h0F0F0F; req1_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (done0 !== 1'b1 || req1_ready !== 1'b0) begin
            errors++; $display("FAIL handoff_done_cycle got done0=%b ready1=%b want 1 0", done0, req1_ready);
        end
        @(negedge clk);
        checks++;
        if (req1_ready !== 1'b1 || cyc != t + 209) begin
            errors++; $display("FAIL handoff_next got ready1=%b cycle %0d want 1 at %0d", req1_ready, cyc, t + 209);
        end
        @(posedge clk); #2;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        int          t1 = -1, t2 = -1, tdone = -1, first_fall = -1, last_fall = -1, nfall = 0;
        int          gap_min = 1000, gap_max = 0;
        logic        pv = 1'b1;
        logic [23:0] fcap = 0;
        @(posedge clk); #2;
        f_req0_data = 24'h5A5A5A; f_req0_valid = 1'b1;
        for (int i = 0; i < 50 && t1 < 0; i++) begin
            @(negedge clk);
            if (f_req0_ready) t1 = cyc;
        end
        for (int i = 0; i < 200 && t2 < 0; i++) begin
            @(negedge clk);
            if (pv && !f_sclk && tdone < 0) begin
                if (first_fall < 0) first_fall = cyc;
                else begin
                    if (cyc - last_fall < gap_min) gap_min = cyc - last_fall;
                    if (cyc - last_fall > gap_max) gap_max = cyc - last_fall;
                end
                last_fall = cyc; nfall++;
                fcap = {fcap[22:0], f_sdio0};
            end
            pv = f_sclk;
            if (f_done0 && tdone < 0) tdone = cyc;
            if (f_req0_ready) t2 = cyc;
        end
        @(posedge clk); #2;
        f_req0_valid = 1'b0;
        checks++;
        if (t1 < 0 || first_fall != t1 + 3) begin
            errors++; $display("FAIL fast_first_fall got %0d want %0d", first_fall, t1 + 3);
        end
        checks++;
        if (gap_min != 4 || gap_max != 4 || nfall != 24) begin
            errors++; $display("FAIL fast_sclk got min %0d max %0d n %0d want 4 4 24", gap_min, gap_max, nfall);
        end
        checks++;
        if (fcap !== 24'h5A5A5A) begin errors++; $display("FAIL fast_data got %h want 5a5a5a", fcap); end
        checks++;
        if (tdone != t1 + 101) begin errors++; $display("FAIL fast_done got %0d want %0d", tdone, t1 + 101); end
        checks++;
        if (t2 != t1 + 102) begin errors++; $display("FAIL fast_reaccept got %0d want %0d", t2, t1 + 102); end
        repeat (120) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_frame0();
        test_frame1();
        test_abort();
        test_arbitration();
        test_done_handoff();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
